// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and sample types for the audio output path
package audio_pkg;
    localparam int I2S_MODE_PHILIPS = 1;
    localparam int I2S_MODE_LJ      = 0;
    localparam int DATA_W_DEF       = 16;
    localparam int SLOT_W_DEF       = 32;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } sample_pair_t;
endpackage

// File: rtl/sync_sample_fifo.sv
// sync_sample_fifo: synchronous FIFO with occupancy count and registered not-full flag
module sync_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   ready,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;
    logic [AW:0]      level_nxt;

    always_comb begin
        do_push   = push && ready;
        do_pop    = pop && !empty;
        level_nxt = level + LW'(do_push) - LW'(do_pop);
    end

    assign empty = level == '0;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so level < DEPTH is just the top bit clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ready <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            level <= level_nxt;
            ready <= !level_nxt[AW];
        end
    end
endmodule

// File: rtl/i2s_stream_tx.sv
// i2s_stream_tx: FIFO-buffered stereo I2S / left-justified serializer with mclk/sck/lrck generation
module i2s_stream_tx
    import audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int SCK_DIV    = 4,
    parameter int MCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int I2S_MODE   = I2S_MODE_PHILIPS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        mute,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_left,
    input  logic [DATA_W-1:0]           s_right,
    output logic                        audio_mclk,
    output logic                        audio_lrck,
    output logic                        audio_sck,
    output logic                        audio_sdin,
    output logic                        frame_start,
    output logic                        underrun,
    output logic [15:0]                 underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DCW  = $clog2(SCK_DIV);
    localparam int BCW  = $clog2(2 * SLOT_W);
    localparam int MCW  = $clog2(MCLK_DIV);
    localparam int LEAD = SLOT_W - DATA_W - (I2S_MODE == I2S_MODE_PHILIPS ? 1 : 0);

    logic [DCW-1:0]      div_cnt;
    logic [BCW-1:0]      bit_cnt;
    logic [MCW-1:0]      mclk_cnt;
    logic                run_q, div_wrap, bit_wrap, mclk_wrap, fb, empty;
    logic                sck_nxt, lrck_nxt, sdin_nxt;
    logic [SLOT_W-1:0]   left_sr, right_sr, load_l, load_r;
    logic [2*DATA_W-1:0] fifo_out;
    logic [15:0]         cnt_nxt;

    sync_sample_fifo #(.WIDTH(2 * DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (fb),
        .wdata ({s_left, s_right}),
        .rdata (fifo_out),
        .ready (s_ready),
        .empty (empty),
        .level (fifo_level)
    );

    // Each slot image is the sample placed MSB-first after the optional I2S delay bit
    always_comb begin
        div_wrap  = div_cnt == DCW'(SCK_DIV - 1);
        bit_wrap  = bit_cnt == BCW'(2 * SLOT_W - 1);
        mclk_wrap = mclk_cnt == MCW'(MCLK_DIV / 2 - 1);
        fb        = enable && !rst && (!run_q || (div_wrap && bit_wrap));
        load_l    = (mute || empty) ? '0 : SLOT_W'(fifo_out[2*DATA_W-1:DATA_W]) << LEAD;
        load_r    = (mute || empty) ? '0 : SLOT_W'(fifo_out[DATA_W-1:0]) << LEAD;
        sck_nxt   = div_cnt >= DCW'(SCK_DIV / 2);
        lrck_nxt  = bit_cnt >= BCW'(SLOT_W);
        sdin_nxt  = !run_q ? load_l[SLOT_W-1] : lrck_nxt ? right_sr[SLOT_W-1] : left_sr[SLOT_W-1];
        cnt_nxt   = (fb && empty && underrun_cnt != 16'hFFFF) ? underrun_cnt + 16'd1 : underrun_cnt;
    end

    assign frame_start = fb;
    assign underrun    = fb && empty;

    // On a start-up boundary the counters already sit at bit 0, so sdin takes the fresh load directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            mclk_cnt     <= '0;
            run_q        <= 1'b0;
            left_sr      <= '0;
            right_sr     <= '0;
            underrun_cnt <= '0;
            audio_mclk   <= 1'b0;
            audio_sck    <= 1'b0;
            audio_lrck   <= 1'b0;
            audio_sdin   <= 1'b0;
        end else begin
            run_q        <= enable;
            underrun_cnt <= cnt_nxt;
            mclk_cnt     <= mclk_wrap ? '0 : mclk_cnt + MCW'(1);
            if (mclk_wrap) audio_mclk <= !audio_mclk;
            if (enable) begin
                div_cnt    <= div_wrap ? '0 : div_cnt + DCW'(1);
                if (div_wrap) bit_cnt <= bit_wrap ? '0 : bit_cnt + BCW'(1);
                audio_sck  <= sck_nxt;
                audio_lrck <= lrck_nxt;
                audio_sdin <= sdin_nxt;
            end else begin
                div_cnt    <= '0;
                bit_cnt    <= '0;
                audio_sck  <= 1'b0;
                audio_lrck <= 1'b0;
                audio_sdin <= 1'b0;
            end
            if (fb) begin
                left_sr  <= load_l;
                right_sr <= load_r;
            end else if (enable && div_wrap && lrck_nxt) begin
                right_sr <= right_sr << 1;
            end else if (enable && div_wrap) begin
                left_sr  <= left_sr << 1;
            end
        end
    end
endmodule

// File: doc/i2s_stream_tx.md
Name: i2s_stream_tx

Overview:
- Parametrised successor to the existing fixed 16-bit speaker serializer. It is a stereo I2S / left-justified transmitter with configurable sample width, slot width and clock ratios.
- Adds a ready/valid sample input buffered by a small FIFO, mute, enable gating and underrun accounting.
- Sits between the note generator / mixer and the audio DAC pins in the top level.

Parameters:
- DATA_W, 16: sample width per channel (8..24).
- SLOT_W, 32: sck cycles per channel slot. Must be ≥ DATA_W, and ≥ DATA_W+1 when I2S_MODE=1.
- SCK_DIV, 4: clk cycles per sck period (even, ≥2).
- MCLK_DIV, 4: clk cycles per mclk period (even, ≥2).
- FIFO_DEPTH, 4: stereo sample pairs buffered (power of 2, ≥2).
- I2S_MODE, 1: 1 = Philips I2S (one-bit delay); 0 = left-justified.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run serializer
- mute  in  1  transmit zeros, still consume samples
- s_valid  in  1  sample pair valid
- s_ready  out  1  FIFO not full
- s_left  in  DATA_W  left sample, two's complement
- s_right  in  DATA_W  right sample, two's complement
- audio_mclk  out  1  master clock
- audio_lrck  out  1  word select, low = left
- audio_sck  out  1  serial bit clock
- audio_sdin  out  1  serial data, MSB first
- frame_start  out  1  one-clk pulse at each frame boundary
- underrun  out  1  one-clk pulse when a frame boundary finds the FIFO empty
- underrun_cnt  out  16  saturating underrun count
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (async, immediate):
  - All outputs 0 except s_ready=1.
  - FIFO flushed; div_cnt=0, bit_cnt=0; shift registers 0; underrun_cnt=0.
- mclk:
  - Free-running regardless of enable.
  - Toggles every MCLK_DIV/2 clk.
- Counters while enable=1:
  - div_cnt counts 0..SCK_DIV-1 and wraps.
  - bit_cnt (0..2*SLOT_W-1) increments when div_cnt wraps and wraps at 2*SLOT_W-1.
- Frame boundary (fb):
  - fb is true on the first clk with enable=1 after enable=0 or reset.
  - fb is also true when div_cnt=SCK_DIV-1 and bit_cnt=2*SLOT_W-1.
- Actions on fb:
  - Pop one pair if FIFO non-empty and load it into the left/right shift regs. If mute=1, load zeros but still pop.
  - If FIFO empty: load zeros, pulse underrun, increment underrun_cnt (saturate at 16'hFFFF).
  - frame_start pulses in the same cycle as fb.
- Output timing: all pin outputs are registered and reflect counter state one clk later.
  - audio_sck = 1 when div_cnt ≥ SCK_DIV/2.
  - audio_lrck = 1 when bit_cnt ≥ SLOT_W.
  - sdin changes only while sck is low; DAC samples on the sck rising edge.
- Slot bit mapping (p = bit_cnt mod SLOT_W, channel selected by lrck):
  - I2S_MODE=1: p=0 sends 0; p=1..DATA_W sends sample[DATA_W-p]; remaining positions send 0.
  - I2S_MODE=0: p=0..DATA_W-1 sends sample[DATA_W-1-p]; remaining positions send 0.
- enable=0:
  - Counters held at 0 next clk; sck, lrck, sdin driven 0.
  - FIFO contents, underrun_cnt and mclk unaffected.
  - Deassertion mid-frame abandons the frame; the popped sample is lost.
- FIFO:
  - Push when s_valid && s_ready.
  - s_ready = (fifo_level < FIFO_DEPTH), registered from current level.
  - Push and pop in the same clk: level unchanged, both honoured.
  - Full plus pop: s_ready rises the clk after the pop.
  - FIFO preserves order.
- mute, and the sample content of a frame, are captured only at fb.

Decomposition:
- Package audio_pkg:
  - I2S_MODE_PHILIPS=1 and I2S_MODE_LJ=0.
  - Default DATA_W/SLOT_W constants.
  - Sample-pair struct typedef {left, right}.
- Sub-module sync_sample_fifo (parametrised width 2*DATA_W and depth) holds storage, pointers and level.
- Serializer, counters and clock generation stay in i2s_stream_tx.

Test Plan:
- Reset check: assert rst mid-run → all outputs 0, s_ready=1, fifo_level=0, underrun_cnt=0 within the same clk.
- I2S frame, defaults: push L=16'hA5C3, R=16'h0F0F, then enable=1. Sample sdin on sck rising edges →
  - lrck low for 32 sck: bit0=0, bits 1..16 = A5C3 MSB first, rest 0.
  - lrck high for 32 sck: same layout with 0F0F.
  - Frame length 256 clk.
- Left-justified (I2S_MODE=0): same stimulus → MSB of A5C3 on the first sck after each lrck edge, 16 data bits then 16 zeros.
- Underrun: enable with FIFO empty for 3 frames → sdin all 0, three underrun pulses spaced 256 clk, underrun_cnt=3. Force count to FFFF → stays FFFF.
- Full/backpressure: push 4 pairs with enable=0 → s_ready=0 and level=4, 5th push ignored. Enable → level=3 at first fb, s_ready=1 next clk, output order matches push order.
- Mute and enable drop: mute=1 with 2 queued pairs → sdin 0 for 2 frames, level reaches 0. Drop enable mid-frame → sck/lrck/sdin 0 next clk, FIFO level retained.
